// File: rtl/seven_seg_display_n.sv
// N-digit multiplexed common-anode seven-segment driver. Binary input is converted
// to BCD one bit per clock (double dabble), or shown as raw hex nibbles.
module seven_seg_display_n #(
    parameter int NUM_DIGITS  = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  mode_hex,
    input  logic                  blank_lz,
    input  logic [NUM_DIGITS-1:0] dp_in,
    output logic [6:0]            segs,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  busy,
    output logic                  overflow
);

    localparam int BCD_DIGITS  = (DATA_WIDTH * 302 + 999) / 1000 + 1;
    localparam int BCD_W       = 4 * BCD_DIGITS;
    localparam int HEX_DIGITS  = (DATA_WIDTH + 3) / 4;
    localparam int MAX_SRC     = (BCD_DIGITS > HEX_DIGITS) ? BCD_DIGITS : HEX_DIGITS;
    localparam int WIDE_DIGITS = (MAX_SRC > NUM_DIGITS) ? MAX_SRC : NUM_DIGITS;
    localparam int DISP_W      = 4 * NUM_DIGITS;
    localparam int CNT_W       = $clog2(DATA_WIDTH);
    localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int REF_W       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic {
        S_IDLE,
        S_CONV
    } state_e;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]        bcd_q, bcd_d;
    logic                    hex_q, hex_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DISP_W-1:0]       disp_q, disp_d;
    logic                    ovf_q, ovf_d;
    logic [REF_W-1:0]        rcnt_q, rcnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [6:0]              segs_q, segs_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    logic [BCD_W+DATA_WIDTH-1:0] shiftVec;
    logic [BCD_W-1:0]            bcdStep;
    logic [DATA_WIDTH-1:0]       binStep;
    logic [4*WIDE_DIGITS-1:0]    wideVal;
    logic                        ovfCalc;
    logic [NUM_DIGITS-1:0]       zeroFrom;
    logic                        allZero;
    logic [3:0]                  curNib;

    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign shiftVec = {add3(bcd_q), bin_q} << 1;
    assign bcdStep  = shiftVec[BCD_W+DATA_WIDTH-1:DATA_WIDTH];
    assign binStep  = shiftVec[DATA_WIDTH-1:0];

    // Candidate display value: finished BCD while converting, raw binary otherwise.
    always_comb begin
        wideVal = '0;
        if (state_q == S_CONV) wideVal[BCD_W-1:0] = bcdStep;
        else                   wideVal[DATA_WIDTH-1:0] = bin_q;
        ovfCalc = 1'b0;
        for (int i = NUM_DIGITS; i < WIDE_DIGITS; i++) begin
            ovfCalc = ovfCalc | (wideVal[4*i +: 4] != 4'd0);
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        hex_d   = hex_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (hex_q) begin
                    disp_d = wideVal[DISP_W-1:0];
                    ovf_d  = ovfCalc;
                end
                bin_d = data_in;
                hex_d = mode_hex;
                bcd_d = '0;
                cnt_d = '0;
                if (!mode_hex) state_d = S_CONV;
            end
            default: begin
                bin_d = binStep;
                bcd_d = bcdStep;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                    state_d = S_IDLE;
                    disp_d  = wideVal[DISP_W-1:0];
                    ovf_d   = ovfCalc;
                end
            end
        endcase
    end

    always_comb begin
        rcnt_d = rcnt_q + 1'b1;
        idx_d  = idx_q;
        if (rcnt_q == REF_W'(REFRESH_DIV - 1)) begin
            rcnt_d = '0;
            idx_d  = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    // zeroFrom[k] is set when digit k and everything to its left are zero.
    always_comb begin
        allZero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            allZero     = allZero & (disp_q[4*k +: 4] == 4'd0);
            zeroFrom[k] = allZero;
        end
        curNib = disp_q[4*idx_q +: 4];
        an_d   = ~(NUM_DIGITS'(1) << idx_q);
        dp_d   = ~dp_in[idx_q];
        if (ovf_q)                                             segs_d = 7'b0111111;
        else if (blank_lz && (idx_q != '0) && zeroFrom[idx_q]) segs_d = 7'h7F;
        else                                                   segs_d = seg7(curNib);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            hex_q   <= 1'b0;
            cnt_q   <= '0;
            disp_q  <= '0;
            ovf_q   <= 1'b0;
            rcnt_q  <= '0;
            idx_q   <= '0;
            segs_q  <= 7'h7F;
            dp_q    <= 1'b1;
            an_q    <= '1;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            hex_q   <= hex_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
            rcnt_q  <= rcnt_d;
            idx_q   <= idx_d;
            segs_q  <= segs_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
        end
    end

    assign segs     = segs_q;
    assign dp       = dp_q;
    assign an       = an_q;
    assign busy     = (state_q == S_CONV);
    assign overflow = ovf_q;

endmodule

// File: doc/seven_seg_display_n.md
Name: seven_seg_display_n

Overview:
- Parametrised successor to the fixed 4-digit switch-to-seven-segment path.
- Samples an unsigned binary word and converts it to BCD with an iterative shift-add-3 (double dabble) engine, one bit per clock. A hex bypass mode skips the conversion.
- Drives an N-digit, time-multiplexed, common-anode display with leading-zero blanking, per-digit decimal points and overflow indication.
- Sits between the switch/data source and the board segment/anode pins.

Parameters:
- NUM_DIGITS, 4, number of display digits (1..8).
- DATA_WIDTH, 16, width of the input word (4..32).
- REFRESH_DIV, 100000, clocks each digit stays lit per scan step (≥1).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- data_in  input  DATA_WIDTH  unsigned value to display.
- mode_hex  input  1  1 = hexadecimal nibbles, 0 = decimal.
- blank_lz  input  1  1 = blank leading zero digits.
- dp_in  input  NUM_DIGITS  active-high decimal point per digit; bit 0 is the rightmost digit.
- segs  output  7  active-low segments, segs[0]=CA … segs[6]=CG.
- dp  output  1  active-low decimal point.
- an  output  NUM_DIGITS  active-low one-hot anode select; an[0] is the rightmost digit.
- busy  output  1  conversion in progress.
- overflow  output  1  displayed value does not fit in NUM_DIGITS.

Behaviour:
- Reset (reset=0, async): segs=7'h7F, dp=1, an=all 1, busy=0, overflow=0. Display register, digit index and refresh counter are cleared. Any conversion in progress is aborted.
- Capture: while busy=0, each clock samples data_in and mode_hex into working registers. Inputs are ignored while busy=1.
- Decimal path:
  - busy=1 for exactly DATA_WIDTH clocks after capture.
  - Internal BCD width is ceil(DATA_WIDTH*0.302)+1 digits, so the engine never saturates.
  - On the clock busy falls, the display register and overflow load atomically; busy=0 that same cycle.
  - The new value is visible on segs from the following clock (capture-to-visible = DATA_WIDTH+2 clocks).
- Hex path: no busy; the display register loads on the clock after capture.
- Overflow:
  - Decimal: set when value > 10^NUM_DIGITS−1.
  - Hex: set when any bit above 4*NUM_DIGITS−1 is 1.
  - While overflow=1, every digit shows '-' (segs=7'b0111111) and dp is still honoured.
  - overflow changes only when the display register loads.
- Scan:
  - The refresh counter counts 0..REFRESH_DIV−1. At terminal count the digit index increments, wrapping NUM_DIGITS−1→0.
  - Outputs are registered: on the first clock after reset release an[0]=0 and all other an bits are 1.
  - Only one anode is ever low. No ghosting cycle: an, segs and dp update on the same edge.
- Blanking: digit k>0 shows segs=7'h7F when blank_lz=1 and digits k..NUM_DIGITS−1 are all zero. Digit 0 is never blanked; a value of 0 shows '0'.
- Encodings, active-low, bit order G..A:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- dp = ~dp_in[index], registered with the other outputs. dp is not blanked.
- Simultaneous events: a data_in change on the cycle busy falls is not captured. It is captured on the next clock, when busy=0.

Test Plan:
All scenarios use NUM_DIGITS=4, DATA_WIDTH=16, REFRESH_DIV=2.
1. Hold reset=0, then release → all outputs at reset values while reset is low; an=4'b1110, segs=1000000 on the first clock after release.
2. data_in=456, decimal, blank_lz=1 → busy high for 16 clocks. Scan then shows:
   - an[0]: 0000010
   - an[1]: 0010010
   - an[2]: 0011001
   - an[3]: 1111111
   - overflow=0
3. data_in=16012, decimal → overflow=1, all four digits 0111111. Switch to mode_hex=1 → digits C,8,E,3 (1000110, 0000000, 0000110, 0110000), overflow=0, display updated 2 clocks after the mode change.
4. data_in=1024, blank_lz=0 vs 1 → both show 1,0,2,4 (no leading zeros). Then data_in=5 → digits 0,0,0,5 with blank_lz=0; blank, blank, blank, 5 with blank_lz=1.
5. Apply 9998, change to 652 on the 3rd busy cycle → 9998 displayed first, then 652 after a second full conversion. Setting dp_in=4'b0100 gives dp=0 only while an[2]=0.
6. Assert reset mid-conversion (busy cycle 8) → busy=0 and outputs at reset values immediately. After release a fresh conversion of the current data_in completes normally.
